// File: rtl/rgb_to_yuv444.sv
// Pipelined RGB to YCbCr 4:4:4 converter, BT.601 full or studio range.
// Three register stages: products, rounded sums, shift/offset/clamp.
module rgb_to_yuv444 #(
    parameter bit STUDIO_RANGE = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] R,
    input  logic [7:0] G,
    input  logic [7:0] B,
    input  logic       in_hsync,
    input  logic       in_vsync,
    output logic       out_valid,
    output logic [7:0] Y,
    output logic [7:0] U,
    output logic [7:0] V,
    output logic       out_hsync,
    output logic       out_vsync
);

    localparam int PW = 18;
    localparam int SW = 20;

    typedef logic signed [PW-1:0] prod_t;
    typedef logic signed [SW-1:0] sum_t;

    localparam prod_t K_YR = STUDIO_RANGE ? prod_t'(66)  : prod_t'(77);
    localparam prod_t K_YG = STUDIO_RANGE ? prod_t'(129) : prod_t'(150);
    localparam prod_t K_YB = STUDIO_RANGE ? prod_t'(25)  : prod_t'(29);
    localparam prod_t K_UR = STUDIO_RANGE ? prod_t'(-38) : prod_t'(-43);
    localparam prod_t K_UG = STUDIO_RANGE ? prod_t'(-74) : prod_t'(-85);
    localparam prod_t K_UB = STUDIO_RANGE ? prod_t'(112) : prod_t'(128);
    localparam prod_t K_VR = STUDIO_RANGE ? prod_t'(112) : prod_t'(128);
    localparam prod_t K_VG = STUDIO_RANGE ? prod_t'(-94) : prod_t'(-107);
    localparam prod_t K_VB = STUDIO_RANGE ? prod_t'(-18) : prod_t'(-21);

    localparam sum_t Y_OFF = STUDIO_RANGE ? sum_t'(16) : sum_t'(0);
    localparam sum_t C_OFF = sum_t'(128);
    localparam sum_t RND   = sum_t'(128);

    // Coefficient times zero-extended 8-bit channel value.
    function automatic prod_t mul(input prod_t k, input logic [7:0] x);
        prod_t xs;
        xs = $signed({{(PW-8){1'b0}}, x});
        return k * xs;
    endfunction

    // Saturate a signed result into 0..255.
    function automatic logic [7:0] sat(input sum_t v);
        if (v < sum_t'(0))
            return 8'd0;
        else if (v > sum_t'(255))
            return 8'hff;
        else
            return v[7:0];
    endfunction

    prod_t p_yr, p_yg, p_yb;
    prod_t p_ur, p_ug, p_ub;
    prod_t p_vr, p_vg, p_vb;
    sum_t  s_y, s_u, s_v;
    logic [7:0] y_q, u_q, v_q;
    logic [2:0] vld_q, hs_q, vs_q;

    // Stage 1: register the nine coefficient products.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_yr <= '0; p_yg <= '0; p_yb <= '0;
            p_ur <= '0; p_ug <= '0; p_ub <= '0;
            p_vr <= '0; p_vg <= '0; p_vb <= '0;
        end else begin
            p_yr <= mul(K_YR, R);
            p_yg <= mul(K_YG, G);
            p_yb <= mul(K_YB, B);
            p_ur <= mul(K_UR, R);
            p_ug <= mul(K_UG, G);
            p_ub <= mul(K_UB, B);
            p_vr <= mul(K_VR, R);
            p_vg <= mul(K_VG, G);
            p_vb <= mul(K_VB, B);
        end
    end

    // Stage 2: sign-extended sums with the rounding constant.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_y <= '0;
            s_u <= '0;
            s_v <= '0;
        end else begin
            s_y <= sum_t'(p_yr) + sum_t'(p_yg) + sum_t'(p_yb) + RND;
            s_u <= sum_t'(p_ur) + sum_t'(p_ug) + sum_t'(p_ub) + RND;
            s_v <= sum_t'(p_vr) + sum_t'(p_vg) + sum_t'(p_vb) + RND;
        end
    end

    // Stage 3: floor shift, add offset, saturate.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q <= '0;
            u_q <= '0;
            v_q <= '0;
        end else begin
            y_q <= sat((s_y >>> 8) + Y_OFF);
            u_q <= sat((s_u >>> 8) + C_OFF);
            v_q <= sat((s_v >>> 8) + C_OFF);
        end
    end

    // Valid and sync ride a 3-deep chain alongside the data.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            hs_q  <= '0;
            vs_q  <= '0;
        end else begin
            vld_q <= {vld_q[1:0], in_valid};
            hs_q  <= {hs_q[1:0], in_hsync};
            vs_q  <= {vs_q[1:0], in_vsync};
        end
    end

    assign out_valid = vld_q[2];
    assign out_hsync = hs_q[2];
    assign out_vsync = vs_q[2];
    assign Y = y_q;
    assign U = u_q;
    assign V = v_q;

endmodule

// File: tb/tb_rgb_to_yuv444.sv
// Bench for rgb_to_yuv444: full and studio instances on shared stimulus,
// checked every cycle against an arithmetic reference with history queue.
module tb_rgb_to_yuv444;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] R, G, B;
    logic       in_hsync, in_vsync;

    logic       ov0, hs0, vs0;
    logic [7:0] y0, u0, v0;
    logic       ov1, hs1, vs1;
    logic [7:0] y1, u1, v1;

    int n_tests = 0;
    int n_fail  = 0;

    rgb_to_yuv444 #(.STUDIO_RANGE(1'b0)) dut_full (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .R(R), .G(G), .B(B),
        .in_hsync(in_hsync), .in_vsync(in_vsync),
        .out_valid(ov0), .Y(y0), .U(u0), .V(v0),
        .out_hsync(hs0), .out_vsync(vs0)
    );

    rgb_to_yuv444 #(.STUDIO_RANGE(1'b1)) dut_studio (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .R(R), .G(G), .B(B),
        .in_hsync(in_hsync), .in_vsync(in_vsync),
        .out_valid(ov1), .Y(y1), .U(u1), .V(v1),
        .out_hsync(hs1), .out_vsync(vs1)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rst;
        bit vld;
        bit hs;
        bit vs;
        int r;
        int g;
        int b;
    } samp_t;

    samp_t hist[$];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic int clamp(input int x);
        if (x < 0) return 0;
        if (x > 255) return 255;
        return x;
    endfunction

    function automatic void conv(input bit st, input int r, input int g,
                                 input int b, output int y, output int u,
                                 output int v);
        int ys, us, vs;
        if (st) begin
            ys = 66*r + 129*g + 25*b + 128;
            us = -38*r - 74*g + 112*b + 128;
            vs = 112*r - 94*g - 18*b + 128;
            y = clamp((ys >>> 8) + 16);
        end else begin
            ys = 77*r + 150*g + 29*b + 128;
            us = -43*r - 85*g + 128*b + 128;
            vs = 128*r - 107*g - 21*b + 128;
            y = clamp(ys >>> 8);
        end
        u = clamp((us >>> 8) + 128);
        v = clamp((vs >>> 8) + 128);
    endfunction

    // Record what every clock edge sampled; keep the last three.
    always @(posedge clk) begin
        samp_t s;
        s.rst = rst;
        s.vld = in_valid;
        s.hs  = in_hsync;
        s.vs  = in_vsync;
        s.r   = int'(R);
        s.g   = int'(G);
        s.b   = int'(B);
        hist.push_back(s);
        if (hist.size() > 3) void'(hist.pop_front());
    end

    // Output at this point reflects the input sampled two edges ago,
    // unless a reset was seen anywhere along the way.
    always @(negedge clk) begin
        bit any_rst;
        bit ev, ehs, evs;
        int ey, eu, ev_;
        if (hist.size() == 3) begin
            any_rst = hist[0].rst || hist[1].rst || hist[2].rst;
            ev  = !any_rst && hist[0].vld;
            ehs = !any_rst && hist[0].hs;
            evs = !any_rst && hist[0].vs;
            chk("full_valid", int'(ov0), int'(ev));
            chk("full_hsync", int'(hs0), int'(ehs));
            chk("full_vsync", int'(vs0), int'(evs));
            chk("std_valid",  int'(ov1), int'(ev));
            chk("std_hsync",  int'(hs1), int'(ehs));
            chk("std_vsync",  int'(vs1), int'(evs));
            if (hist[2].rst) begin
                chk("full_y_rst", int'(y0), 0);
                chk("full_u_rst", int'(u0), 0);
                chk("full_v_rst", int'(v0), 0);
                chk("std_y_rst",  int'(y1), 0);
                chk("std_u_rst",  int'(u1), 0);
                chk("std_v_rst",  int'(v1), 0);
            end else if (ev) begin
                conv(1'b0, hist[0].r, hist[0].g, hist[0].b, ey, eu, ev_);
                chk("full_y", int'(y0), ey);
                chk("full_u", int'(u0), eu);
                chk("full_v", int'(v0), ev_);
                conv(1'b1, hist[0].r, hist[0].g, hist[0].b, ey, eu, ev_);
                chk("std_y", int'(y1), ey);
                chk("std_u", int'(u1), eu);
                chk("std_v", int'(v1), ev_);
            end
        end
    end

    task automatic cyc(input bit r_, input bit v, input int rr,
                       input int gg, input int bb,
                       input bit hs, input bit vs);
        rst      = r_;
        in_valid = v;
        R        = 8'(rr);
        G        = 8'(gg);
        B        = 8'(bb);
        in_hsync = hs;
        in_vsync = vs;
        @(posedge clk);
        #1;
    endtask

    task automatic pin(input string name, input bit st, input int r,
                       input int g, input int b, input int xy,
                       input int xu, input int xv);
        int y, u, v;
        conv(st, r, g, b, y, u, v);
        chk({name, "_y"}, y, xy);
        chk({name, "_u"}, u, xu);
        chk({name, "_v"}, v, xv);
    endtask

    initial begin
        int lat;
        int gv;
        rst = 1'b1; in_valid = 1'b1;
        R = '0; G = '0; B = '0;
        in_hsync = 1'b0; in_vsync = 1'b0;

        pin("ref_red",   1'b0, 255, 0, 0, 77, 85, 255);
        pin("ref_green", 1'b0, 0, 255, 0, 149, 43, 21);
        pin("ref_blue",  1'b0, 0, 0, 255, 29, 255, 107);
        pin("ref_white", 1'b0, 255, 255, 255, 255, 128, 128);
        pin("ref_black", 1'b0, 0, 0, 0, 0, 128, 128);
        pin("ref_grey",  1'b0, 100, 100, 100, 100, 128, 128);
        pin("ref_swhite", 1'b1, 255, 255, 255, 235, 128, 128);
        pin("ref_sblack", 1'b1, 0, 0, 0, 16, 128, 128);

        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++)
            cyc(1'b1, 1'b1, $urandom_range(0, 255),
                $urandom_range(0, 255), $urandom_range(0, 255),
                1'b1, 1'b1);
        for (int k = 0; k < 3; k++)
            cyc(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);

        rst = 1'b0; in_valid = 1'b1;
        R = 8'd255; G = 8'd0; B = 8'd0;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (ov0 && lat == 0) begin
                lat = k;
                chk("lat_red_y", int'(y0), 77);
                chk("lat_red_v", int'(v0), 255);
            end
        end
        chk("latency", lat, 3);

        cyc(1'b0, 1'b1, 255, 0, 0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 0, 255, 0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 0, 0, 255, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 255, 255, 255, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            gv = $urandom_range(0, 255);
            cyc(1'b0, 1'b1, gv, gv, gv, 1'b0, 1'b0);
        end

        for (int k = 0; k < 20; k++)
            cyc(1'b0, k[0] == 1'b0, $urandom_range(0, 255),
                $urandom_range(0, 255), $urandom_range(0, 255),
                1'b0, 1'b0);

        for (int k = 0; k < 40; k++)
            cyc(1'b0, 1'b1, $urandom_range(0, 255),
                $urandom_range(0, 255), $urandom_range(0, 255),
                k == 10, k == 25);

        for (int k = 0; k < 2; k++)
            cyc(1'b0, 1'b1, 10, 200, 30, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 10, 200, 30, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
            chk("post_rst_quiet", int'(ov0), 0);
        end

        for (int k = 0; k < 400; k++)
            cyc($urandom_range(0, 80) == 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 255), $urandom_range(0, 255),
                $urandom_range(0, 255), $urandom_range(0, 9) == 0,
                $urandom_range(0, 19) == 0);

        for (int k = 0; k < 5; k++)
            cyc(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rgb_to_yuv444.md
Name: rgb_to_yuv444

Overview:
- Pipelined colour-space converter: one 8-bit RGB pixel per clock in, one 8-bit YCbCr 4:4:4 pixel (Y, U=Cb, V=Cr) per clock out.
- Sits in the video datapath between the RGB pixel source and the downstream chroma subsampler or encoder.
- Video sync signals travel with the pixels, delay-matched, so timing stays aligned.

Parameters:
- STUDIO_RANGE, 0, coefficient set. 0 selects BT.601 full range (JPEG). 1 selects BT.601 studio range (Y 16..235, U/V 16..240).

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  R/G/B/sync inputs carry a pixel this cycle.
- R  in  8  red, unsigned.
- G  in  8  green, unsigned.
- B  in  8  blue, unsigned.
- in_hsync  in  1  horizontal sync, passed through.
- in_vsync  in  1  vertical sync, passed through.
- out_valid  out  1  Y/U/V/sync outputs carry a converted pixel.
- Y  out  8  luma, unsigned.
- U  out  8  Cb, unsigned, offset 128.
- V  out  8  Cr, unsigned, offset 128.
- out_hsync  out  1  in_hsync delayed by the pipeline latency.
- out_vsync  out  1  in_vsync delayed by the pipeline latency.

Behaviour:
- Reset: while rst=1 at a clock edge, all pipeline registers clear. out_valid, Y, U, V, out_hsync and out_vsync are all 0. Reset mid-stream discards in-flight pixels. The first output after reset release follows the normal latency.
- Latency is fixed at 3 clocks from input sample to output. There is no backpressure: the pipeline advances every clock.
  - Stage 1: register the nine coefficient products.
  - Stage 2: register the three signed sums, including the rounding constant 128.
  - Stage 3: arithmetic shift right by 8, add the offset, clamp to 0..255, register the outputs.
- Valid and sync: in_valid, in_hsync and in_vsync shift through a 3-deep register chain in parallel with the data. Data registers load every cycle regardless of valid. Downstream must qualify Y/U/V with out_valid.
- Full-range coefficients (STUDIO_RANGE=0):
  - Y = (77R + 150G + 29B + 128) >>> 8
  - U = ((-43R - 85G + 128B + 128) >>> 8) + 128
  - V = ((128R - 107G - 21B + 128) >>> 8) + 128
- Studio-range coefficients (STUDIO_RANGE=1):
  - Y = ((66R + 129G + 25B + 128) >>> 8) + 16
  - U = ((-38R - 74G + 112B + 128) >>> 8) + 128
  - V = ((112R - 94G - 18B + 128) >>> 8) + 128
- Arithmetic rules:
  - Products and sums use signed arithmetic at least 18 bits wide, so no intermediate overflow is possible.
  - >>> is an arithmetic (floor) shift.
  - Results below 0 clamp to 0; results above 255 clamp to 255. Saturation, never wrap.
- Grey inputs (R=G=B) give U=V=128 exactly.

Test Plan:
- Reset: hold rst=1 for 2 clocks with in_valid=1 and any RGB -> all outputs 0 during reset. out_valid first rises exactly 3 clocks after the first valid input following release.
- Primaries, full range, back-to-back valid pixels:
  - (255,0,0) -> Y=77, U=85, V=255 (clamped from 256).
  - (0,255,0) -> Y=149, U=43, V=21.
  - (0,0,255) -> Y=29, U=255 (clamped), V=107.
- White and black: (255,255,255) -> Y=255, U=128, V=128. (0,0,0) -> Y=0, U=128, V=128.
- Sync alignment: pulse in_hsync for 1 clock on pixel N of a streaming sequence -> out_hsync pulses on the same cycle pixel N appears on Y/U/V. Repeat the check for in_vsync.
- Valid gaps and mid-stream reset: alternate in_valid 1/0 -> out_valid reproduces the pattern delayed by 3. Assert rst while pixels are in flight -> no out_valid from pre-reset pixels.
- Studio range (STUDIO_RANGE=1): (255,255,255) -> Y=235, U=128, V=128. (0,0,0) -> Y=16, U=128, V=128.
